// File: rtl/bound_flasher_ctrl.sv
// bound_flasher_ctrl: tick-paced bound-flasher lamp sequencer (LED ramps with flick kickbacks).
// Define BOUND_FLASHER_BLINK_EN to append the two on/off blinks after the final ramp-down.
module bound_flasher_ctrl #(
    parameter int LED_NUM   = 16,
    parameter int LOW_BOUND = 6,
    parameter int MID_BOUND = 11
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tick,
    input  logic               flick,
    output logic [LED_NUM-1:0] led,
    output logic               busy,
    output logic [2:0]         state
);
    localparam int CW = $clog2(LED_NUM + 1);
    localparam logic [CW-1:0] LB = CW'(LOW_BOUND);
    localparam logic [CW-1:0] MB = CW'(MID_BOUND);
    localparam logic [CW-1:0] LN = CW'(LED_NUM);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        UP_LOW  = 3'd1,
        DN_ZERO = 3'd2,
        UP_MID  = 3'd3,
        DN_LOW  = 3'd4,
        UP_ALL  = 3'd5,
        DN_END  = 3'd6,
        BLINK   = 3'd7
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d, inc, dec;
    logic [LED_NUM-1:0] led_q, led_d;
    logic               busy_q, hold;
`ifdef BOUND_FLASHER_BLINK_EN
    logic [1:0]         blink_q, blink_d;
`endif

    // Between ticks everything holds, except an unused encoding which recovers at once.
`ifdef BOUND_FLASHER_BLINK_EN
    assign hold = !tick;
`else
    assign hold = !tick && 3'(state_q) != 3'd7;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        inc     = cnt_q + 1'b1;
        dec     = cnt_q - 1'b1;
`ifdef BOUND_FLASHER_BLINK_EN
        blink_d = blink_q;
`endif
        case (state_q)
            IDLE:    state_d = flick ? UP_LOW : IDLE;
            UP_LOW: begin
                cnt_d   = inc;
                state_d = (inc == LB) ? DN_ZERO : UP_LOW;
            end
            DN_ZERO: begin
                cnt_d   = dec;
                state_d = (dec == '0) ? UP_MID : DN_ZERO;
            end
            UP_MID: begin
                cnt_d   = (cnt_q == LB && flick) ? dec : inc;
                state_d = (cnt_q == LB && flick) ? DN_ZERO : (inc == MB) ? DN_LOW : UP_MID;
            end
            DN_LOW: begin
                cnt_d   = dec;
                state_d = (dec <= LB - 1'b1) ? UP_ALL : DN_LOW;
            end
            UP_ALL: begin
                cnt_d   = ((cnt_q == LB || cnt_q == MB) && flick) ? dec : inc;
                state_d = ((cnt_q == LB || cnt_q == MB) && flick) ? DN_LOW :
                          (inc == LN) ? DN_END : UP_ALL;
            end
            DN_END: begin
                cnt_d = dec;
`ifdef BOUND_FLASHER_BLINK_EN
                state_d = (dec == '0) ? BLINK : DN_END;
`else
                state_d = (dec == '0) ? IDLE : DN_END;
`endif
            end
`ifdef BOUND_FLASHER_BLINK_EN
            BLINK: begin
                blink_d = blink_q + 1'b1;
                state_d = (blink_q == 2'd3) ? IDLE : BLINK;
            end
`endif
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        if (hold) begin
            state_d = state_q;
            cnt_d   = cnt_q;
`ifdef BOUND_FLASHER_BLINK_EN
            blink_d = blink_q;
`endif
        end
        led_d = '0;
        for (int i = 0; i < LED_NUM; i++) led_d[i] = CW'(i) < cnt_d;
`ifdef BOUND_FLASHER_BLINK_EN
        if (state_d == BLINK) led_d = {LED_NUM{blink_d[0]}};
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            led_q   <= '0;
            busy_q  <= 1'b0;
`ifdef BOUND_FLASHER_BLINK_EN
            blink_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            busy_q  <= state_d != IDLE;
`ifdef BOUND_FLASHER_BLINK_EN
            blink_q <= blink_d;
`endif
        end
    end

    assign led   = led_q;
    assign busy  = busy_q;
    assign state = state_q;

    a_cnt_range: assert property (@(posedge clk) disable iff (!rst) cnt_q <= LN);
`ifndef BOUND_FLASHER_BLINK_EN
    a_no_blink: assert property (@(posedge clk) disable iff (!rst) 3'(state_q) != 3'd7);
`endif
endmodule
